// File: rtl/ballot_controller.sv
// Ballot-session sequencer: one registered vote pulse per issued ballot, with multi-press
// rejection, overflow guard and poll close. Optional ARMED expiry under `BALLOT_TIMEOUT_EN`.
module ballot_controller #(
    parameter int NUM_CAND = 3,
    parameter int CNT_W    = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_ballot,
    input  logic [NUM_CAND-1:0] vote_btn,
    input  logic                close_poll,
    output logic [NUM_CAND-1:0] vote_pulse,
    output logic                ready,
    output logic                invalid,
    output logic                timed_out,
    output logic                full,
    output logic                poll_closed,
    output logic [CNT_W-1:0]    total_votes
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_CAST    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_CLOSED  = 3'd4;

    localparam logic [NUM_CAND-1:0] BTN_ONE   = {{(NUM_CAND-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    TOTAL_MAX = {CNT_W{1'b1}};

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [NUM_CAND-1:0] latched;
    logic                close_req;
    logic                any_btn;
    logic                one_hot;
    logic                multi;
    logic                expire;
    logic                set_invalid;
    logic                set_timeout;

    always_comb begin
        any_btn = |vote_btn;
        one_hot = any_btn && ((vote_btn & (vote_btn - BTN_ONE)) == '0);
        multi   = any_btn && !one_hot;
    end

`ifdef BALLOT_TIMEOUT_EN
    localparam int TMR_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TMR_W-1:0] tmr;

    // The ballot stays ARMED for TIMEOUT cycles; the last one is the expiry cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr <= '0;
        end else if (state != S_ARMED && state_nxt == S_ARMED) begin
            tmr <= TMR_W'(TIMEOUT);
        end else if (state == S_ARMED && tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
        end
    end

    assign expire = (tmr <= TMR_W'(1));
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        set_invalid = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (close_poll) begin
                    state_nxt = S_CLOSED;
                end else if (issue_ballot && !full) begin
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                // Close aborts the ballot even if a valid press lands in the same cycle.
                if (close_poll) begin
                    state_nxt = S_CLOSED;
                end else begin
                    set_invalid = multi;
                    if (one_hot) begin
                        state_nxt = S_CAST;
                    end else if (expire) begin
                        state_nxt   = S_IDLE;
                        set_timeout = 1'b1;
                    end
                end
            end
            S_CAST: begin
                state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!any_btn) begin
                    state_nxt = (close_req || close_poll) ? S_CLOSED : S_IDLE;
                end
            end
            S_CLOSED: begin
                state_nxt = S_CLOSED;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            vote_pulse  <= '0;
            ready       <= 1'b0;
            invalid     <= 1'b0;
            timed_out   <= 1'b0;
            full        <= 1'b0;
            poll_closed <= 1'b0;
            total_votes <= '0;
            close_req   <= 1'b0;
        end else begin
            state       <= state_nxt;
            ready       <= (state_nxt == S_ARMED);
            invalid     <= set_invalid;
            timed_out   <= set_timeout;
            poll_closed <= (state_nxt == S_CLOSED);
            vote_pulse  <= (state == S_CAST) ? latched : '0;
            if (state == S_CAST) begin
                total_votes <= total_votes + CNT_W'(1);
                full        <= ((total_votes + CNT_W'(1)) == TOTAL_MAX);
                if (close_poll) begin
                    close_req <= 1'b1;
                end
            end
        end
    end

    // Button capture is pure data; it is only consumed in CAST after a fresh latch.
    always_ff @(posedge clk) begin
        if (state == S_ARMED && one_hot) begin
            latched <= vote_btn;
        end
    end

endmodule

// File: tb/tb_ballot_controller.sv
// Self-checking bench for ballot_controller: directed scenarios plus randomized ballots
// checked against a transaction-level vote model (total, per-candidate tallies, full).
module tb_ballot_controller;

    localparam int NC  = 3;
    localparam int CW  = 4;
    localparam int TMO = 4;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          issue_ballot = 1'b0;
    logic [NC-1:0] vote_btn = '0;
    logic          close_poll = 1'b0;
    logic [NC-1:0] vote_pulse;
    logic          ready;
    logic          invalid;
    logic          timed_out;
    logic          full;
    logic          poll_closed;
    logic [CW-1:0] total_votes;

    int checks = 0;
    int errors = 0;
    int exp_total;
    int exp_cand [NC];
    int tally [NC];

    ballot_controller #(.NUM_CAND(NC), .CNT_W(CW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .issue_ballot(issue_ballot), .vote_btn(vote_btn),
        .close_poll(close_poll), .vote_pulse(vote_pulse), .ready(ready), .invalid(invalid),
        .timed_out(timed_out), .full(full), .poll_closed(poll_closed), .total_votes(total_votes)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) if (vote_pulse[i] === 1'b1) tally[i]++;
    endtask

    task automatic model_clear();
        exp_total = 0;
        for (int i = 0; i < NC; i++) begin
            exp_cand[i] = 0;
            tally[i] = 0;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pulse"}, 32'(vote_pulse), 0);
        chk({tag, "_ready"}, 32'(ready), 0);
        chk({tag, "_invalid"}, 32'(invalid), 0);
        chk({tag, "_timed_out"}, 32'(timed_out), 0);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_closed"}, 32'(poll_closed), 0);
        chk({tag, "_total"}, 32'(total_votes), 0);
    endtask

    task automatic do_reset();
        issue_ballot = 1'b0;
        vote_btn = '0;
        close_poll = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        chk_reset_vals("reset");
    endtask

    // One complete ballot: optional rejected multi-press, then a valid press held `hold` extra cycles.
    task automatic do_ballot(input logic [NC-1:0] pre, input logic [NC-1:0] btn, input int hold);
        int cand;
        issue_ballot = 1'b1;
        tick();
        issue_ballot = 1'b0;
        chk("ready_armed", 32'(ready), 1);
        if ($countones(pre) >= 2) begin
            vote_btn = pre;
            repeat (2) begin
                tick();
                chk("invalid_multi", 32'(invalid), 1);
                chk("pulse_multi", 32'(vote_pulse), 0);
                chk("ready_multi", 32'(ready), 1);
            end
        end
        vote_btn = btn;
        tick();
        chk("ready_drop", 32'(ready), 0);
        chk("invalid_single", 32'(invalid), 0);
        chk("pulse_early", 32'(vote_pulse), 0);
        tick();
        exp_total++;
        cand = 0;
        for (int i = 0; i < NC; i++) if (btn[i]) cand = i;
        exp_cand[cand]++;
        chk("pulse_cast", 32'(vote_pulse), 32'(btn));
        chk("total_cast", 32'(total_votes), 32'(exp_total));
        chk("full_cast", 32'(full), 32'(exp_total == MAXV));
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("pulse_held", 32'(vote_pulse), 0);
            chk("ready_held", 32'(ready), 0);
        end
        vote_btn = '0;
        tick();
        chk("pulse_release", 32'(vote_pulse), 0);
        chk("ready_release", 32'(ready), 0);
    endtask

    initial begin
        logic [NC-1:0] pre;
        logic [NC-1:0] btn;
        int n;

        do_reset();
        tick();
        chk_reset_vals("idle");

        // Single vote with a long hold, then a held button in IDLE must not vote.
        do_ballot('0, 3'b010, 5);
        vote_btn = 3'b010;
        repeat (3) begin
            tick();
            chk("idle_press_pulse", 32'(vote_pulse), 0);
            chk("idle_press_ready", 32'(ready), 0);
        end
        vote_btn = '0;
        chk("total_after_idle_press", 32'(total_votes), 1);

        do_ballot(3'b101, 3'b001, 1);

        // Randomized ballots up to the overflow limit.
        while (exp_total < MAXV) begin
            pre = NC'($urandom_range(0, 7));
            if ($countones(pre) < 2) pre = '0;
            btn = NC'(1 << $urandom_range(0, NC - 1));
            repeat ($urandom_range(0, 2)) begin
                tick();
                chk("gap_ready", 32'(ready), 0);
            end
            do_ballot(pre, btn, $urandom_range(0, 3));
        end
        chk("full_set", 32'(full), 1);
        chk("total_max", 32'(total_votes), MAXV);
        for (int i = 0; i < NC; i++) chk("cand_tally", 32'(tally[i]), 32'(exp_cand[i]));
        issue_ballot = 1'b1;
        repeat (3) begin
            tick();
            chk("full_ready", 32'(ready), 0);
            chk("full_total", 32'(total_votes), MAXV);
        end
        issue_ballot = 1'b0;

        // Reset while ARMED.
        do_reset();
        issue_ballot = 1'b1;
        tick();
        issue_ballot = 1'b0;
        chk("armed_before_reset", 32'(ready), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("mid_reset");
        vote_btn = 3'b001;
        tick();
        tick();
        chk("after_reset_pulse", 32'(vote_pulse), 0);
        vote_btn = '0;
        tick();

        // Close and a valid press in the same ARMED cycle: abort, no vote.
        do_ballot('0, 3'b100, 0);
        issue_ballot = 1'b1;
        tick();
        issue_ballot = 1'b0;
        close_poll = 1'b1;
        vote_btn = 3'b100;
        tick();
        close_poll = 1'b0;
        chk("close_armed_closed", 32'(poll_closed), 1);
        chk("close_armed_ready", 32'(ready), 0);
        n = 0;
        repeat (3) begin
            tick();
            n += $countones(vote_pulse);
        end
        chk("close_armed_pulses", 32'(n), 0);
        chk("close_armed_total", 32'(total_votes), 1);
        vote_btn = '0;
        issue_ballot = 1'b1;
        tick();
        tick();
        chk("closed_ignores_issue", 32'(ready), 0);
        chk("closed_sticky", 32'(poll_closed), 1);
        issue_ballot = 1'b0;

        // Close during CAST: the vote completes, then the poll closes after release.
        do_reset();
        issue_ballot = 1'b1;
        tick();
        issue_ballot = 1'b0;
        vote_btn = 3'b001;
        tick();
        close_poll = 1'b1;
        tick();
        close_poll = 1'b0;
        chk("cast_close_pulse", 32'(vote_pulse), 1);
        chk("cast_close_total", 32'(total_votes), 1);
        chk("cast_close_open", 32'(poll_closed), 0);
        tick();
        chk("cast_close_held", 32'(poll_closed), 0);
        vote_btn = '0;
        tick();
        chk("cast_close_closed", 32'(poll_closed), 1);

`ifdef BALLOT_TIMEOUT_EN
        // Unpressed ballot expires after TIMEOUT armed cycles.
        do_reset();
        issue_ballot = 1'b1;
        tick();
        issue_ballot = 1'b0;
        n = (ready === 1'b1) ? 1 : 0;
        for (int k = 0; k < 50 && ready === 1'b1; k++) begin
            tick();
            if (ready === 1'b1) n++;
        end
        chk("tmo_dwell", 32'(n), TMO);
        chk("tmo_flag", 32'(timed_out), 1);
        tick();
        chk("tmo_flag_drop", 32'(timed_out), 0);
        chk("tmo_total", 32'(total_votes), 0);
        chk("tmo_pulse", 32'(vote_pulse), 0);
`else
        chk("timed_out_tied", 32'(timed_out), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
